// File: rtl/test_i12913_pkg.sv
// Shared constants and types for the test_i12913 logic benchmark.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package test_i12913_pkg;

   // Width of the rare-event counter.
   localparam int EVT_W = 4;

   // Input pattern {N0,N1,N2,N3,N4} that advances the counter.
   localparam logic [4:0] EVT_PAT = 5'b11111;

   // Saturation value; the counter holds here and flips the output.
   localparam logic [EVT_W-1:0] EVT_MAX = {EVT_W{1'b1}};

   typedef logic [EVT_W-1:0] evt_cnt_t;

endpackage

// File: rtl/test_i12913_if.sv
// Bundle of the five data inputs and the single result bit.
// Latency: n/a (signal grouping only).
// Backpressure: none; a new input vector may be applied every cycle.
interface test_i12913_if;

   logic N0;
   logic N1;
   logic N2;
   logic N3;
   logic N4;
   logic Y;

   // Driver of the input vector, consumer of the result.
   modport master (
      output N0, N1, N2, N3, N4,
      input  Y
   );

   // The benchmark block itself.
   modport slave (
      input  N0, N1, N2, N3, N4,
      output Y
   );

endinterface

// File: rtl/test_i12913_evt_ctr.sv
// Saturating event counter that advances by one on each cycle 'hit' is high.
// Latency: cnt/sat reflect a hit one CK edge later.
// Backpressure: none; once saturated, further hits are ignored until reset.
module test_i12913_evt_ctr
   import test_i12913_pkg::*;
(
   input  logic     CK,
   input  logic     reset,
   input  logic     hit,
   output evt_cnt_t cnt,
   output logic     sat
);

   // Count hits, hold at the maximum, and clear only on reset.
   always_ff @(posedge CK) begin
      if (reset) begin
         cnt <= '0;
      end else if (hit && !sat) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign sat = (cnt == EVT_MAX);

endmodule

// File: rtl/test_i12913.sv
// Shift/XOR pipeline plus a combinational cone, with the output inverted once the event counter saturates.
// Latency: Y is combinational from N; state contributes after 1 to 3 CK edges.
// Backpressure: none; one input vector is consumed every cycle.
module test_i12913
   import test_i12913_pkg::*;
(
   input  logic          CK,
   input  logic          reset,
   test_i12913_if.slave  bus
);

   logic       q0;
   logic       q1;
   logic       q2;
   logic [4:0] n_vec;
   logic       hit;
   logic       trig;
   logic       base;
   evt_cnt_t   evt_cnt;

   // N0 is the most significant bit of the harness's vector.
   assign n_vec = {bus.N0, bus.N1, bus.N2, bus.N3, bus.N4};
   assign hit   = (n_vec == EVT_PAT);

   // Three-stage pipeline; each stage mixes fresh inputs with the previous stage.
   always_ff @(posedge CK) begin
      if (reset) begin
         q0 <= 1'b0;
         q1 <= 1'b0;
         q2 <= 1'b0;
      end else begin
         q0 <= bus.N0 ^ bus.N1;
         q1 <= (bus.N2 & bus.N3) | q0;
         q2 <= bus.N4 ^ q1;
      end
   end

   test_i12913_evt_ctr u_ctr (
      .CK    (CK),
      .reset (reset),
      .hit   (hit),
      .cnt   (evt_cnt),
      .sat   (trig)
   );

   // Output cone: pipeline tail gated by N4, a direct AND path, and a saturation flip.
   always_comb begin
      base  = (q2 & ~bus.N4) | (bus.N0 & bus.N1 & bus.N2);
      bus.Y = base ^ trig;
   end

endmodule

// File: tb/tb_test_i12913.sv
// Self-checking bench: a driver issues vectors and queues expected results; a monitor compares.
// Latency: expectation for a vector is checked in the same cycle it is applied.
// Backpressure: none.
module tb_test_i12913;

   logic CK;
   logic reset;

   test_i12913_if bus ();

   test_i12913 dut (
      .CK    (CK),
      .reset (reset),
      .bus   (bus)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   typedef struct {
      logic       y;
      logic [3:0] cnt;
      logic [4:0] vec;
      string      tag;
   } exp_t;

   exp_t       exp_q[$];
   int         n_vec = 0;
   int         n_bad = 0;

   // Reference model state: inputs seen at non-reset edges since the last reset,
   // and how many of those edges carried the all-ones pattern.
   logic [4:0] hist[$];
   int         hits = 0;
   bit         model_valid = 1'b0;

   // Input vector applied k edges ago (zero if the reset happened more recently).
   function automatic logic [4:0] past(input int k);
      if (hist.size() >= k) return hist[hist.size() - k];
      return 5'b00000;
   endfunction

   // Y from the specified equations, with the pipeline unrolled over input history.
   function automatic logic model_y(input logic [4:0] v);
      logic [4:0] x1, x2, x3;
      logic       q2, trig, base;
      x1   = past(1);
      x2   = past(2);
      x3   = past(3);
      // bit 4 = N0 ... bit 0 = N4
      q2   = x1[0] ^ ((x2[2] & x2[1]) | (x3[4] ^ x3[3]));
      trig = (hits >= 15);
      base = (q2 & ~v[0]) | (v[4] & v[3] & v[2]);
      return base ^ trig;
   endfunction

   function automatic logic [3:0] model_cnt();
      if (hits >= 15) return 4'd15;
      return 4'(hits);
   endfunction

   // Apply one vector for one cycle; queue the expected response for the monitor.
   task automatic step(input logic [4:0] v, input logic rst, input string tag);
      exp_t e;
      @(negedge CK);
      bus.N0 = v[4];
      bus.N1 = v[3];
      bus.N2 = v[2];
      bus.N3 = v[1];
      bus.N4 = v[0];
      reset  = rst;
      if (model_valid) begin
         e.y   = model_y(v);
         e.cnt = model_cnt();
         e.vec = v;
         e.tag = tag;
         exp_q.push_back(e);
      end
      @(posedge CK);
      if (rst) begin
         hist.delete();
         hits        = 0;
         model_valid = 1'b1;
      end else begin
         hist.push_back(v);
         if (hist.size() > 8) void'(hist.pop_front());
         if (v == 5'b11111) hits++;
      end
   endtask

   // Monitor: compare the presented output against the oldest queued expectation.
   initial begin
      exp_t m;
      forever begin
         @(negedge CK);
         #3;
         if (exp_q.size() > 0) begin
            m = exp_q.pop_front();
            n_vec++;
            if (bus.Y !== m.y || dut.evt_cnt !== m.cnt) begin
               n_bad++;
               $display("FAIL %s vec=%05b: got Y=%b cnt=%0d, expected Y=%b cnt=%0d",
                        m.tag, m.vec, bus.Y, dut.evt_cnt, m.y, m.cnt);
            end
         end
      end
   end

   // Absolute bound on run time.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, %0d vectors checked", n_vec);
      $fatal(1, "timeout");
   end

   initial begin
      logic [4:0] v;
      logic       r;
      reset  = 1'b1;
      bus.N0 = 1'b0;
      bus.N1 = 1'b0;
      bus.N2 = 1'b0;
      bus.N3 = 1'b0;
      bus.N4 = 1'b0;

      // Idle after reset.
      step(5'b00000, 1'b1, "rst");
      repeat (3) step(5'b00000, 1'b0, "idle");

      // Direct AND path right after reset.
      step(5'b00000, 1'b1, "rst");
      step(5'b11100, 1'b0, "and_path");

      // N0 alone travels through the pipeline to Y after three edges.
      step(5'b00000, 1'b1, "rst");
      repeat (4) step(5'b10000, 1'b0, "n0_pipe");
      step(5'b10001, 1'b0, "n4_gate");

      // Saturate the counter, then confirm it holds.
      step(5'b00000, 1'b1, "rst");
      repeat (16) step(5'b11111, 1'b0, "sat_fill");
      step(5'b00000, 1'b0, "sat_idle");
      repeat (20) step(5'b11111, 1'b0, "sat_hold");
      step(5'b00000, 1'b0, "sat_hold_end");

      // Reset while saturated and while the pattern is present.
      step(5'b11100, 1'b1, "rst_sat");
      step(5'b11100, 1'b0, "after_rst_sat");
      step(5'b11111, 1'b1, "rst_pat");
      step(5'b00000, 1'b0, "after_rst_pat");

      // Full sweep from reset.
      step(5'b00000, 1'b1, "rst");
      for (int i = 0; i < 32; i++) step(5'(i), 1'b0, "sweep");
      step(5'b00000, 1'b0, "sweep_end");

      // Random vectors, biased toward the counting pattern, with occasional resets.
      for (int i = 0; i < 400; i++) begin
         v = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 2) == 0) v = 5'b11111;
         r = ($urandom_range(0, 39) == 0);
         step(v, r, "random");
      end

      repeat (2) @(negedge CK);
      #5;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
